// File: rtl/decode_pkg.sv
// Shared types and encodings for the registered decode stage: the control word layout,
// RV opcode/funct fields and the ALU/branch selector enums.
package decode_pkg;

  localparam int unsigned OFFSET_W = 5;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] F3Ld     = 3'b011;
  localparam logic [2:0] F3Sd     = 3'b011;
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Blt    = 3'b100;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Sub  = 7'b0100000;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_LT   = 2'b10
  } br_e;

  typedef struct packed {
    logic                reg_write_enable;
    logic [4:0]          reg_read_addr_1;
    logic [4:0]          reg_read_addr_2;
    logic [4:0]          reg_write_addr;
    logic                data_write_enable;
    logic [4:0]          data_read_addr;
    logic [4:0]          data_write_addr;
    alu_e                alu_ctrl;
    logic                reg_write_select;
    br_e                 branch;
    logic                branch_direction;
    logic [OFFSET_W-1:0] branch_offset;
  } decode_t;

  localparam int unsigned DecodeW = $bits(decode_t);

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder: inst -> control word, load flag and illegal flag.
// Illegal flagging is only produced when DECODE_ILLEGAL_TRAP_EN is defined.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]        inst_i,
  output logic [DecodeW-1:0] ctrl_o,
  output logic               illegal_o,
  output logic               is_load_o
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  decode_t    d;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];

  // Unused read ports stay zero; the hazard check in the stage relies on that.
  always_comb begin
    d         = '0;
    is_load_o = 1'b0;
    case (opcode)
      OpLoad: begin
        if (funct3 == F3Ld) begin
          is_load_o          = 1'b1;
          d.reg_write_enable = 1'b1;
          d.reg_read_addr_1  = rs1;
          d.reg_write_addr   = rd;
          d.data_read_addr   = rs2;
          d.alu_ctrl         = ALU_ADD;
          d.reg_write_select = 1'b0;
        end
      end
      OpStore: begin
        if (funct3 == F3Sd) begin
          d.reg_read_addr_1   = rs1;
          d.reg_read_addr_2   = rs2;
          d.data_write_enable = 1'b1;
          d.data_write_addr   = rd;
          d.alu_ctrl          = ALU_ADD;
        end
      end
      OpReg: begin
        d.reg_write_enable = 1'b1;
        d.reg_read_addr_1  = rs1;
        d.reg_read_addr_2  = rs2;
        d.reg_write_addr   = rd;
        d.reg_write_select = 1'b1;
        if (funct7 == F7Base && funct3 == F3And)         d.alu_ctrl = ALU_AND;
        else if (funct7 == F7Base && funct3 == F3Or)     d.alu_ctrl = ALU_OR;
        else if (funct7 == F7Base && funct3 == F3AddSub) d.alu_ctrl = ALU_ADD;
        else if (funct7 == F7Sub && funct3 == F3AddSub)  d.alu_ctrl = ALU_SUB;
        else                                             d = '0;
      end
      OpBranch: begin
        if (funct3 == F3Beq || funct3 == F3Blt) begin
          d.reg_read_addr_1  = rs1;
          d.reg_read_addr_2  = rs2;
          d.alu_ctrl         = ALU_SUB;
          d.branch           = (funct3 == F3Beq) ? BR_EQ : BR_LT;
          d.branch_direction = inst_i[25];
          d.branch_offset    = OFFSET_W'(rd);
        end
      end
      default: d = '0;
    endcase
  end

  assign ctrl_o = d;

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Every supported encoding sets a write enable or a branch, so zero means unsupported.
  assign illegal_o = (d == '0);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoded-entry FIFO with valid/ready on both sides, load-use
// stall FSM and branch flush. Illegal trapping follows DECODE_ILLEGAL_TRAP_EN in decode_comb.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        inst_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DecodeW-1:0] out_ctrl_o,
  output logic               illegal_o
);

  localparam int unsigned PtrW   = $clog2(BUF_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned StallW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;

  typedef enum logic {StRun, StStall} state_e;

  logic [DecodeW-1:0] dec_ctrl;
  decode_t            dec;
  logic               dec_illegal, dec_is_load;

  decode_comb u_decode_comb (
    .inst_i    (inst_i),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .is_load_o (dec_is_load)
  );

  decode_t              mem_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] ill_q;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  state_e               state_q, state_d;
  logic [StallW-1:0]    stall_cnt_q, stall_cnt_d;
  logic                 trk_valid_q, trk_valid_d;
  logic [4:0]           trk_rd_q, trk_rd_d;
  logic                 full, hazard, push, pop;

  assign dec  = decode_t'(dec_ctrl);
  assign full = (cnt_q == CntW'(BUF_DEPTH));

  // Tracked rd is never x0 and unused read fields decode to x0, so no false matches.
  assign hazard = (STALL_CYCLES != 0) && in_valid_i && trk_valid_q &&
                  ((dec.reg_read_addr_1 == trk_rd_q) || (dec.reg_read_addr_2 == trk_rd_q));

  assign in_ready_o  = !rst_i && !flush_i && !full && (state_q == StRun) && !hazard;
  assign push        = in_valid_i && in_ready_o;
  assign out_valid_o = (cnt_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign out_ctrl_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign illegal_o   = out_valid_o && ill_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    trk_valid_d = trk_valid_q;
    trk_rd_d    = trk_rd_q;
    if (flush_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      state_d     = StRun;
      stall_cnt_d = '0;
      trk_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
      unique case (state_q)
        StRun: begin
          if (hazard) begin
            state_d     = StStall;
            stall_cnt_d = StallW'(STALL_CYCLES);
          end else if (push) begin
            trk_valid_d = dec_is_load && (dec.reg_write_addr != 5'd0);
            trk_rd_d    = dec.reg_write_addr;
          end
        end
        StStall: begin
          if (stall_cnt_q <= StallW'(1)) begin
            state_d     = StRun;
            stall_cnt_d = '0;
            trk_valid_d = 1'b0;
          end else begin
            stall_cnt_d = stall_cnt_q - StallW'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= StRun;
      stall_cnt_q <= '0;
      trk_valid_q <= 1'b0;
      trk_rd_q    <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      trk_valid_q <= trk_valid_d;
      trk_rd_q    <= trk_rd_d;
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec;
      ill_q[wr_ptr_q] <= dec_illegal;
    end
  end

endmodule
